// File: rtl/vga_sync_640x480.sv
// vga_sync_640x480
//   Timing generator for a 640x480@60 Hz VGA display. Derives the pixel rate
//   from the system clock with a clock enable (pixel_tick), so no derived
//   clocks are created. It sweeps the column/line counters across the whole
//   800x525 raster and decodes the sync and visible-area flags from them.
//
//   Optional feature (compile-time macro VGA_SYNC_DELAY_EN):
//     When defined, hsync/vsync/areaAtiva pass through one extra register
//     stage that advances on pixel_tick. They then line up with a registered
//     rgb stage downstream. linha/coluna/frame_start are not delayed.
//
// Ports
//   clk          in   system clock (50 MHz nominal)
//   reset        in   synchronous, active-high
//   pixel_tick   out  one-clk pulse per pixel
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   areaAtiva    out  1 while the current position is in the visible area
//   linha        out  current line, 0..V_TOTAL-1
//   coluna       out  current column, 0..H_TOTAL-1
//   frame_start  out  one-clk pulse when position (0,0) is entered
module vga_sync_640x480 #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       areaAtiva,
  output logic [9:0] linha,
  output logic [9:0] coluna,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VLAST  = 10'(H_VIS - 1);
  localparam logic [9:0] V_VLAST  = 10'(V_VIS - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic       tick_q, tick_d;
  logic [9:0] coluna_q, coluna_d;
  logic [9:0] linha_q, linha_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       frame_q, frame_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
    // The tick is registered from the current divider value, so it first
    // rises two clocks after reset release and never shows during reset.
    tick_d    = (div_cnt_q == DIV_LAST);

    coluna_d  = coluna_q;
    linha_d   = linha_q;
    frame_d   = 1'b0;
    if (tick_q) begin
      if (coluna_q == H_LAST) begin
        coluna_d = 10'd0;
        if (linha_q == V_LAST) begin
          linha_d = 10'd0;
          frame_d = 1'b1;
        end else begin
          linha_d = linha_q + 10'd1;
        end
      end else begin
        coluna_d = coluna_q + 10'd1;
      end
    end

    // Decode from the next counter values so the flags are registered
    // in the same clock as the counters they describe.
    hsync_d  = !((coluna_d >= HS_FIRST) && (coluna_d <= HS_LAST));
    vsync_d  = !((linha_d >= VS_FIRST) && (linha_d <= VS_LAST));
    active_d = (coluna_d <= H_VLAST) && (linha_d <= V_VLAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 4'd0;
      tick_q    <= 1'b0;
      coluna_q  <= 10'd0;
      linha_q   <= 10'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      active_q  <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      coluna_q  <= coluna_d;
      linha_q   <= linha_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      frame_q   <= frame_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q, hsync_dly_d;
  logic vsync_dly_q, vsync_dly_d;
  logic active_dly_q, active_dly_d;

  // The second stage captures the first stage's value for the pixel that
  // is being left, which delays the flags by exactly one pixel.
  always_comb begin
    hsync_dly_d  = tick_q ? hsync_q  : hsync_dly_q;
    vsync_dly_d  = tick_q ? vsync_q  : vsync_dly_q;
    active_dly_d = tick_q ? active_q : active_dly_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_dly_q  <= 1'b1;
      vsync_dly_q  <= 1'b1;
      active_dly_q <= 1'b1;
    end else begin
      hsync_dly_q  <= hsync_dly_d;
      vsync_dly_q  <= vsync_dly_d;
      active_dly_q <= active_dly_d;
    end
  end

  assign hsync     = hsync_dly_q;
  assign vsync     = vsync_dly_q;
  assign areaAtiva = active_dly_q;
`else
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign areaAtiva = active_q;
`endif

  assign pixel_tick  = tick_q;
  assign linha       = linha_q;
  assign coluna      = coluna_q;
  assign frame_start = frame_q;

endmodule
